// File: rtl/cm0_dap_cdc_send_mask.sv
// Launch side of a multi-bit REQ/ACK CDC path: holds a captured word and presents it
// through per-bit glitch-free AND masks, sequenced so data is stable before the mask opens.

module cm0_dap_cdc_comb_and (
    input  logic a_i,
    input  logic b_i,
    output logic z_o
);

    assign z_o = a_i & b_i;

endmodule

module cm0_dap_cdc_send_mask #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PRESENT     = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATAIN,
    output logic             READY,
    output logic             DONE,
    output logic             REQOUT,
    input  logic             ACKIN,
    output logic [WIDTH-1:0] DATAOUT
);

    generate
        if (PRESENT != 0) begin : g_present
            typedef enum logic [1:0] {
                ST_IDLE  = 2'd0,
                ST_SETUP = 2'd1,
                ST_REQ   = 2'd2,
                ST_ACK   = 2'd3
            } state_t;

            state_t                 state_q;
            state_t                 state_d;
            logic [WIDTH-1:0]       data_q;
            logic [WIDTH-1:0]       data_d;
            logic                   mask_q;
            logic                   mask_d;
            logic                   req_q;
            logic                   req_d;
            logic                   ready_q;
            logic                   ready_d;
            logic                   done_q;
            logic                   done_d;
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   ack_s;

            // ACKIN synchroniser chain; only its last stage is visible to the FSM
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], ACKIN};
                end
            end

            assign ack_s = sync_q[SYNC_STAGES-1];

            // State and output registers
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    state_q <= ST_IDLE;
                    data_q  <= '0;
                    mask_q  <= 1'b0;
                    req_q   <= 1'b0;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    data_q  <= data_d;
                    mask_q  <= mask_d;
                    req_q   <= req_d;
                    ready_q <= ready_d;
                    done_q  <= done_d;
                end
            end

            // Next-state decode
            always_comb begin
                state_d = state_q;
                case (state_q)
                    ST_IDLE: begin
                        if (START) begin
                            state_d = ST_SETUP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_SETUP: begin
                        state_d = ST_REQ;
                    end
                    ST_REQ: begin
                        if (ack_s) begin
                            state_d = ST_ACK;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                    ST_ACK: begin
                        if (!ack_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_ACK;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            // Next values of the registered outputs; the mask opens only one edge after data is loaded
            always_comb begin
                data_d  = data_q;
                mask_d  = 1'b0;
                req_d   = 1'b0;
                ready_d = 1'b0;
                done_d  = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (START) begin
                            data_d  = DATAIN;
                            ready_d = 1'b0;
                        end else begin
                            data_d  = data_q;
                            ready_d = 1'b1;
                        end
                    end
                    ST_SETUP: begin
                        mask_d = 1'b1;
                        req_d  = 1'b1;
                    end
                    ST_REQ: begin
                        if (ack_s) begin
                            mask_d = 1'b0;
                            req_d  = 1'b0;
                        end else begin
                            mask_d = 1'b1;
                            req_d  = 1'b1;
                        end
                    end
                    ST_ACK: begin
                        if (!ack_s) begin
                            ready_d = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            ready_d = 1'b0;
                            done_d  = 1'b0;
                        end
                    end
                    default: begin
                        data_d = '0;
                    end
                endcase
            end

            for (genvar i = 0; i < WIDTH; i++) begin : g_mask
                cm0_dap_cdc_comb_and u_and (
                    .a_i (data_q[i]),
                    .b_i (mask_q),
                    .z_o (DATAOUT[i])
                );
            end

            assign READY  = ready_q;
            assign DONE   = done_q;
            assign REQOUT = req_q;
        end else begin : g_absent
            logic unused_inputs_s;

            assign unused_inputs_s = ^{CLK, RESET, START, DATAIN, ACKIN};
            assign READY   = 1'b0;
            assign DONE    = 1'b0;
            assign REQOUT  = 1'b0;
            assign DATAOUT = '0;
        end
    endgenerate

endmodule
